// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - memory bus request/response structs, arbiter state enum and masking helpers
package bundle;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [3:0]  rlen;
    logic        rready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [3:0]  wlen;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
  } bus_query_req_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        rlast;
    logic        awready;
    logic        wready;
    logic        bvalid;
  } bus_query_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_READ  = 2'd1,
    ARB_WRITE = 2'd2
  } arb_state_t;

  // A master is asking for the bus when either address channel is valid.
  function automatic logic req_active(input bus_query_req_t r);
    return r.arvalid | r.awvalid;
  endfunction

  // Read grant: every write-channel field is hidden from the memory side.
  function automatic bus_query_req_t read_view(input bus_query_req_t r);
    bus_query_req_t v;
    v         = r;
    v.awvalid = 1'b0;
    v.awaddr  = '0;
    v.wlen    = '0;
    v.wvalid  = 1'b0;
    v.wdata   = '0;
    v.wstrb   = '0;
    v.wlast   = 1'b0;
    v.bready  = 1'b0;
    return v;
  endfunction

  // Write grant: the read request/acceptance is hidden so it waits for its own grant.
  function automatic bus_query_req_t write_view(input bus_query_req_t r);
    bus_query_req_t v;
    v         = r;
    v.arvalid = 1'b0;
    v.rlen    = '0;
    v.rready  = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - bundled master-side and memory-side bus signals of the arbiter
interface bus_arbiter_if
  import bundle::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ID_W        = $clog2(NUM_MASTERS)
) ();

  bus_query_req_t  [NUM_MASTERS-1:0] m_req;
  bus_query_resp_t [NUM_MASTERS-1:0] m_resp;
  bus_query_req_t                    s_req;
  bus_query_resp_t                   s_resp;
  logic            [ID_W-1:0]        grant_id;
  logic                              busy;

  // Arbiter view.
  modport slave (
    input  m_req,
    input  s_resp,
    output m_resp,
    output s_req,
    output grant_id,
    output busy
  );

  // Environment view: cache masters plus memory controller.
  modport master (
    output m_req,
    output s_resp,
    input  m_resp,
    input  s_req,
    input  grant_id,
    input  busy
  );

endinterface

// File: rtl/bus_arb_picker.sv
// rtl/bus_arb_picker.sv - combinational winner selection; BUS_ARB_ROUND_ROBIN_EN selects round-robin
module bus_arb_picker #(
  parameter int NUM_MASTERS = 3,
  parameter int ID_W        = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [ID_W-1:0]        last_grant,
  output logic                   pick_valid,
  output logic [ID_W-1:0]        pick_id
);

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // Round-robin: scan starting one past the previous winner, wrapping around.
  always_comb begin
    int idx;
    pick_valid = 1'b0;
    pick_id    = '0;
    idx        = 0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      idx = (int'(last_grant) + off) % NUM_MASTERS;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'(idx);
      end
    end
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = ^last_grant;

  // Fixed priority: scanning downward lets the lowest requesting index win.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - burst-granular memory bus arbiter; BUS_ARB_ROUND_ROBIN_EN enables round-robin picking
module bus_arbiter
  import bundle::*;
#(
  parameter int NUM_MASTERS = 3,
  parameter int ID_W        = $clog2(NUM_MASTERS)
) (
  input  logic         clk,
  input  logic         rst_n,
  bus_arbiter_if.slave bus
);

  arb_state_t                       state_q;
  arb_state_t                       state_d;
  logic            [ID_W-1:0]       grant_q;
  logic            [NUM_MASTERS-1:0] req_vec;
  logic                             pick_valid;
  logic            [ID_W-1:0]       pick_id;
  logic            [ID_W-1:0]       last_grant;
  logic            [3:0]            rbeat_cnt_q;
  logic            [3:0]            rlen_q;
  bus_query_req_t                   sel_req;
  bus_query_req_t                   fwd_req;
  bus_query_resp_t [NUM_MASTERS-1:0] resp_vec;
  logic                             take_grant;
  logic                             read_beat;
  logic                             read_done;
  logic                             write_done;

  // Collapse each master's request into one bit for the picker.
  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      req_vec[i] = req_active(bus.m_req[i]);
    end
  end

`ifdef BUS_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_grant_q;

  // Remember the latest winner; reset value makes master 0 first in line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= ID_W'(NUM_MASTERS - 1);
    end else if (take_grant) begin
      last_grant_q <= pick_id;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = '0;
`endif

  bus_arb_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .ID_W        (ID_W)
  ) u_picker (
    .req        (req_vec),
    .last_grant (last_grant),
    .pick_valid (pick_valid),
    .pick_id    (pick_id)
  );

  assign take_grant = (state_q == ARB_IDLE) && pick_valid;
  assign sel_req    = bus.m_req[grant_q];
  assign read_beat  = (state_q == ARB_READ) && bus.s_resp.rvalid && fwd_req.rready;
  assign read_done  = read_beat && bus.s_resp.rlast;
  assign write_done = (state_q == ARB_WRITE) && bus.s_resp.bvalid && fwd_req.bready;

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant index and read-beat bookkeeping, all latched when a grant is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= '0;
      rbeat_cnt_q <= '0;
      rlen_q      <= '0;
    end else if (take_grant) begin
      grant_q     <= pick_id;
      rbeat_cnt_q <= '0;
      rlen_q      <= bus.m_req[pick_id].rlen;
    end else if (read_beat) begin
      rbeat_cnt_q <= rbeat_cnt_q + 4'd1;
    end
  end

  // Next state: writes win over reads from the same master; completion always returns to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d = bus.m_req[pick_id].awvalid ? ARB_WRITE : ARB_READ;
        end
      end
      ARB_READ: begin
        if (read_done) begin
          state_d = ARB_IDLE;
        end
      end
      ARB_WRITE: begin
        if (write_done) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Outputs: mask the granted request per burst type and steer the response to the grant holder only.
  always_comb begin
    fwd_req  = '0;
    resp_vec = '0;
    case (state_q)
      ARB_READ: begin
        fwd_req           = read_view(sel_req);
        resp_vec[grant_q] = bus.s_resp;
      end
      ARB_WRITE: begin
        fwd_req           = write_view(sel_req);
        resp_vec[grant_q] = bus.s_resp;
      end
      default: begin
        fwd_req  = '0;
        resp_vec = '0;
      end
    endcase
  end

  assign bus.s_req    = fwd_req;
  assign bus.m_resp   = resp_vec;
  assign bus.grant_id = grant_q;
  assign bus.busy     = (state_q != ARB_IDLE);

`ifndef SYNTHESIS
  // rlast ends the burst regardless; flag a slave whose beat count disagrees with the requested length.
  a_rlast_len : assert property (@(posedge clk) disable iff (!rst_n)
    read_done |-> (rbeat_cnt_q == rlen_q - 4'd1));
`endif

endmodule
